// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch front end
// Contents:
//   fetch_entry_t : one fetch queue record, the PC and its instruction word
//   NOP_INSTR     : canonical no-op encoding (addi x0, x0, 0)
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular FIFO of fetch entries with synchronous flush
// Ports:
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   push, pop   : enqueue wr_entry / dequeue head (ignored when full / empty)
//   flush       : empties the queue on the next edge, overrides push and pop
//   wr_entry    : record written at the tail on push
//   head_entry  : record at the head, reads 0 while empty
//   count       : occupied entries, full, empty : occupancy flags
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wr_entry,
  output fetch_entry_t           head_entry,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  head;
  logic [AW-1:0]  tail;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= wr_entry;
  end

  assign head_entry = empty ? '0 : mem[head];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - in-order fetch front end: PC, icache lookup, fetch queue
// Ports:
//   clk, reset                 : rising-edge clock, asynchronous active-high reset
//   icache_addr / icache_instr : current PC out, combinational instruction back
//   redirect_valid/redirect_pc : flush queue and restart at word-aligned PC
//   fetch_valid/fetch_ready    : head handshake to decode
//   fetch_pc, fetch_instr      : head entry contents
//   fq_count                   : queue occupancy
//   fetch_done                 : PC past the memory image and queue drained
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 2208,
  parameter int          FQ_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [31:0]               icache_addr,
  input  logic [31:0]               icache_instr,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      fetch_valid,
  input  logic                      fetch_ready,
  output logic [31:0]               fetch_pc,
  output logic [31:0]               fetch_instr,
  output logic [$clog2(FQ_DEPTH):0] fq_count,
  output logic                      fetch_done
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

  logic [31:0]  pc;
  logic         in_range;
  logic         push;
  logic         pop;
  logic         q_full;
  logic         q_empty;
  fetch_entry_t wr_entry;
  fetch_entry_t head_entry;

  assign in_range = (pc < IMEM_LIMIT);
  // Push looks only at registered state, keeping fetch_ready off this path.
  assign push     = !redirect_valid && !q_full && in_range;
  assign pop      = fetch_valid && fetch_ready && !redirect_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  assign wr_entry.pc    = pc;
  assign wr_entry.instr = icache_instr;

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .wr_entry   (wr_entry),
    .head_entry (head_entry),
    .count      (fq_count),
    .full       (q_full),
    .empty      (q_empty)
  );

  assign icache_addr = pc;
  assign fetch_valid = !q_empty;
  assign fetch_pc    = head_entry.pc;
  assign fetch_instr = head_entry.instr;
  assign fetch_done  = !in_range && q_empty;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

In-order instruction fetch front end. Each cycle it drives a byte address into the combinational instruction cache and captures the returned word together with its PC in a small circular fetch queue. It presents the head entry to decode over a valid/ready handshake. It also redirects the PC on a branch mispredict or flush from the back end.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000: byte PC loaded on reset; must be word aligned.
- IMEM_BYTES, 2208: instruction memory size in bytes; fetch stops at this bound.
- FQ_DEPTH, 4: fetch queue entries; power of two, at least 2.

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-high; all state cleared immediately.
- icache_addr  out  32  byte address to the instruction cache; equals the current PC.
- icache_instr  in  32  instruction word returned combinationally for icache_addr.
- redirect_valid  in  1  flush and restart request.
- redirect_pc  in  32  new PC; bits [1:0] are ignored and forced to 0.
- fetch_valid  out  1  queue head is valid.
- fetch_ready  in  1  decode accepts the head this cycle.
- fetch_pc  out  32  PC of the head entry.
- fetch_instr  out  32  instruction of the head entry.
- fq_count  out  $clog2(FQ_DEPTH)+1  number of occupied queue entries.
- fetch_done  out  1  PC is at or beyond IMEM_BYTES and the queue is empty.

## Operation

- State: the PC register, and a queue with head pointer, tail pointer and count.
- push = !redirect_valid && count != FQ_DEPTH && pc < IMEM_BYTES.
- On push, write {pc, icache_instr} at tail, advance tail, and set pc to pc + 4.
- pop = fetch_valid && fetch_ready && !redirect_valid.
- On pop, advance head.
- Count update: count_next = count + push - pop.
- Pop and push in the same cycle is legal at any count below FQ_DEPTH.
- When full, push is 0 even if a pop occurs that cycle. Push depends only on registered count, so there is no combinational path from fetch_ready to the fetch decision.
- Pointers wrap modulo FQ_DEPTH; PC arithmetic is unsigned 32-bit.
- The fetch_* outputs are combinational from the head entry. fetch_valid = (count != 0).
- Redirect has the highest priority:
  - on the next edge count, head and tail go to 0, and pc becomes {redirect_pc[31:2], 2'b00};
  - no push and no pop occur that cycle, even if fetch_ready is high;
  - decode also discards its own state on redirect.
- Exhaustion: once pc >= IMEM_BYTES, pushes stop. The queue keeps draining. fetch_done rises when count reaches 0.
- A redirect to an in-range PC clears exhaustion.
- icache_addr = pc at all times, including while stalled.

## Timing

Reset values:
- pc = RESET_PC; head, tail and count = 0.
- fetch_valid = 0, fq_count = 0, fetch_done = 0 (assuming RESET_PC < IMEM_BYTES).
- fetch_pc and fetch_instr are don't-care while fetch_valid = 0; they read 0 after reset.

Latency:
- First fetch_valid is on the first rising edge after reset deasserts.
- Redirect to first valid is 2 edges: the flush edge, then the push edge for redirect_pc.

Throughput:
- Sustained 1 instruction per cycle with fetch_ready held high.
- With fetch_ready held low, the queue fills in FQ_DEPTH cycles and the PC freezes at RESET_PC + 4*FQ_DEPTH.

Reset mid-operation:
- Asserting reset at any point clears the queue and PC asynchronously.
- Outputs reach their reset values without waiting for a clock edge.

## Structure

- fetch_pkg holds:
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;};
  - constant NOP_INSTR = 32'h0000_0013.
- One sub-module, fetch_queue:
  - parameterised circular FIFO of fetch_entry_t;
  - ports: push, pop, flush, write entry, head entry, count, full, empty.
- fetch_unit owns the PC, push/pop/redirect gating and done logic. It instantiates fetch_queue and connects icache_addr/icache_instr to i_cache.

## Test plan

- Reset then fetch_ready = 1 with a memory image holding 0x00500093 at byte 0 and 0x00108113 at byte 4 -> edge 1: fetch_pc = 0, fetch_instr = 0x00500093; edge 2: fetch_pc = 4, fetch_instr = 0x00108113; fetch_valid stays 1.
- fetch_ready = 0 for 10 cycles, FQ_DEPTH = 4 -> fq_count saturates at 4, icache_addr holds 0x10, head stays pc 0. Releasing ready pops 0, 4, 8, 0xC in order with no gap.
- Full queue with fetch_ready = 1 for one cycle -> the pop happens, no push that cycle, count = 3; the next cycle pushes pc 0x10.
- redirect_valid with redirect_pc = 0x00000043 while count = 3 and fetch_ready = 1 -> next edge count = 0, no pop counted, icache_addr = 0x40; the edge after gives fetch_pc = 0x40.
- IMEM_BYTES = 16, fetch_ready = 1 -> entries 0, 4, 8, 0xC are delivered, then fetch_valid = 0 and fetch_done = 1, with icache_addr held at 0x10. A redirect to 0x4 clears fetch_done and delivers 0x4 two edges later.
- Assert reset asynchronously mid-stream with count = 2 -> fq_count = 0, fetch_valid = 0 and icache_addr = RESET_PC before the next clock edge.
